// File: rtl/ps2_mouse_quad_if.sv
// ps2_mouse_quad_if
//   Groups the PS/2 pad lines and the 7-bit quadrature/key bus for
//   ps2_mouse_quad.
//   msclk  PS/2 clock from pad (asynchronous to clk)
//   msdat  PS/2 data from pad (asynchronous to clk)
//   quad   [6]=~L [5]=~M [4]=~R [3]=xA [2]=xB [1]=yA [0]=yB
//   master: drives the pad lines and observes quad (mouse side / bench)
//   slave : receives the pad lines and drives quad (ps2_mouse_quad)
interface ps2_mouse_quad_if;
    logic       msclk;
    logic       msdat;
    logic [6:0] quad;

    modport master (output msclk, output msdat, input quad);
    modport slave  (input msclk, input msdat, output quad);
endinterface

// File: rtl/ps2_mouse_quad.sv
// ps2_mouse_quad
//   Receives 3-byte PS/2 stream-mode mouse packets and re-emits the motion
//   as 2-phase quadrature step sequences, with the mouse keys as active-low
//   lines, so a PS/2 mouse can drive the existing quadrature decoder.
//   clk  : system clock, all logic on posedge
//   rst  : synchronous, active-low reset
//   bus  : ps2_mouse_quad_if.slave (msclk, msdat in; quad out)
//   Parameters: STEP_DIV clk cycles per quadrature step (>= 2),
//               TIMEOUT  clk cycles without a PS/2 clock fall before a
//                        partial frame/packet is abandoned,
//               ACC_W    width of the saturating pending-step accumulators.
//   Build option: define MQ_PARITY_EN to drop bytes failing odd parity
//   (and restart packet sync); otherwise the parity bit is ignored.
module ps2_mouse_quad #(
    parameter int unsigned STEP_DIV = 1000,
    parameter int unsigned TIMEOUT  = 50000,
    parameter int unsigned ACC_W    = 12
) (
    input logic              clk,
    input logic              rst,
    ps2_mouse_quad_if.slave  bus
);

    localparam int unsigned TW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned OW  = $clog2(TIMEOUT + 1);
    localparam int          SAT = (1 << (ACC_W - 1)) - 1;
    localparam logic signed [ACC_W+1:0] SAT_P = (ACC_W+2)'(SAT);
    localparam logic signed [ACC_W+1:0] SAT_N = (ACC_W+2)'(-SAT);
    localparam logic signed [ACC_W+1:0] ONE   = (ACC_W+2)'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {PK_B0, PK_B1, PK_B2} pk_state_e;

    // Pad synchronisers (idle-high reset so no false fall after reset)
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic dat_s1_q, dat_s2_q;

    rx_state_e rx_q, rx_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
`ifdef MQ_PARITY_EN
    logic       par_q, par_d;
`endif
    pk_state_e  pk_q, pk_d;
    // Header byte minus the always-one bit3: {Yov,Xov,Ys,Xs,M,R,L}
    logic [6:0] hdr_q, hdr_d;
    logic [7:0] b1_q, b1_d;
    logic [OW-1:0] to_q, to_d;
    logic [2:0] keys_q, keys_d;   // {M,R,L}, active-high
    logic signed [ACC_W-1:0] px_q, px_d, py_q, py_d;
    logic [1:0] xph_q, xph_d, yph_q, yph_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [6:0] quad_q, quad_d;

    logic fall, dbit, busy, timeout, byte_ok, par_err, pkt_done, tick;
    logic signed [8:0] dx9, dy9;
    logic [1:0] xinc, yinc;

    assign fall = clk_s3_q & ~clk_s2_q;
    assign dbit = dat_s2_q;
    assign tick = (tmr_q == TW'(STEP_DIV - 1));
    assign busy = (rx_q != RX_IDLE) || (pk_q != PK_B0);
    assign timeout = busy && !fall && (to_q == OW'(TIMEOUT - 1));

    // Add the packet delta and take one step toward zero in the same
    // cycle, then clamp to the symmetric accumulator range.
    function automatic logic signed [ACC_W-1:0] acc_next(
        input logic signed [ACC_W-1:0] p,
        input logic signed [8:0]       d,
        input logic                    add,
        input logic                    step
    );
        logic signed [ACC_W+1:0] s;
        logic signed [ACC_W+1:0] de;
        s  = {{2{p[ACC_W-1]}}, p};
        de = {{(ACC_W-7){d[8]}}, d};
        if (add) s = s + de;
        if (step && (p > 0)) s = s - ONE;
        if (step && (p < 0)) s = s + ONE;
        if (s > SAT_P) s = SAT_P;
        if (s < SAT_N) s = SAT_N;
        return s[ACC_W-1:0];
    endfunction

    // Phase 0..3 -> (A,B) = 00,10,11,01
    function automatic logic [1:0] enc(input logic [1:0] ph);
        return {ph[0] ^ ph[1], ph[1]};
    endfunction

    // Frame receiver
    always_comb begin
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef MQ_PARITY_EN
        par_d     = par_q;
`endif
        byte_ok   = 1'b0;
        par_err   = 1'b0;
        if (timeout) begin
            rx_d      = RX_IDLE;
            bit_cnt_d = '0;
        end else if (fall) begin
            unique case (rx_q)
                RX_IDLE: begin
                    if (!dbit) begin
                        rx_d      = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {dbit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_d = RX_PAR;
                end
                RX_PAR: begin
`ifdef MQ_PARITY_EN
                    par_d = dbit;
`endif
                    rx_d  = RX_STOP;
                end
                RX_STOP: begin
                    rx_d      = RX_IDLE;
                    bit_cnt_d = '0;
                    if (dbit) begin
`ifdef MQ_PARITY_EN
                        if (^{shift_q, par_q}) byte_ok = 1'b1;
                        else                   par_err = 1'b1;
`else
                        byte_ok = 1'b1;
`endif
                    end
                end
                default: rx_d = RX_IDLE;
            endcase
        end
    end

    // Packet assembler
    always_comb begin
        pk_d     = pk_q;
        hdr_d    = hdr_q;
        b1_d     = b1_q;
        pkt_done = 1'b0;
        if (timeout || par_err) begin
            pk_d = PK_B0;
        end else if (byte_ok) begin
            unique case (pk_q)
                PK_B0: begin
                    if (shift_q[3]) begin
                        hdr_d = {shift_q[7:4], shift_q[2:0]};
                        pk_d  = PK_B1;
                    end
                end
                PK_B1: begin
                    b1_d = shift_q;
                    pk_d = PK_B2;
                end
                PK_B2: begin
                    pkt_done = 1'b1;
                    pk_d     = PK_B0;
                end
                default: pk_d = PK_B0;
            endcase
        end
    end

    // Motion, timer and emitter
    always_comb begin
        dx9    = hdr_q[5] ? '0 : {hdr_q[3], b1_q};
        // byte2 is still in the shift register on the accepting cycle
        dy9    = hdr_q[6] ? '0 : {hdr_q[4], shift_q};
        to_d   = (fall || !busy || timeout) ? '0 : to_q + 1'b1;
        tmr_d  = tick ? '0 : tmr_q + 1'b1;
        keys_d = pkt_done ? hdr_q[2:0] : keys_q;
        px_d   = acc_next(px_q, dx9, pkt_done, tick);
        py_d   = acc_next(py_q, dy9, pkt_done, tick);
        xinc   = 2'd0;
        yinc   = 2'd0;
        if (tick && (px_q > 0)) xinc = 2'd1;
        if (tick && (px_q < 0)) xinc = 2'd3;
        if (tick && (py_q > 0)) yinc = 2'd1;
        if (tick && (py_q < 0)) yinc = 2'd3;
        xph_d  = xph_q + xinc;
        yph_d  = yph_q + yinc;
        quad_d = {~keys_d[0], ~keys_d[2], ~keys_d[1], enc(xph_d), enc(yph_d)};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            rx_q      <= RX_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef MQ_PARITY_EN
            par_q     <= 1'b0;
`endif
            pk_q      <= PK_B0;
            hdr_q     <= '0;
            b1_q      <= '0;
            to_q      <= '0;
            keys_q    <= '0;
            px_q      <= '0;
            py_q      <= '0;
            xph_q     <= '0;
            yph_q     <= '0;
            tmr_q     <= '0;
            quad_q    <= 7'b1110000;
        end else begin
            clk_s1_q  <= bus.msclk;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            dat_s1_q  <= bus.msdat;
            dat_s2_q  <= dat_s1_q;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef MQ_PARITY_EN
            par_q     <= par_d;
`endif
            pk_q      <= pk_d;
            hdr_q     <= hdr_d;
            b1_q      <= b1_d;
            to_q      <= to_d;
            keys_q    <= keys_d;
            px_q      <= px_d;
            py_q      <= py_d;
            xph_q     <= xph_d;
            yph_q     <= yph_d;
            tmr_q     <= tmr_d;
            quad_q    <= quad_d;
        end
    end

    assign bus.quad = quad_q;

endmodule

// File: tb/tb_ps2_mouse_quad.sv
// tb_ps2_mouse_quad
//   Self-checking bench for ps2_mouse_quad. A negedge monitor decodes the
//   quadrature outputs into signed step counts per axis and flags illegal
//   phase jumps or wrong step spacing; directed packets are applied from a
//   vector table, followed by hand-written multi-cycle sequences.
module tb_ps2_mouse_quad;

    localparam int SD   = 16;
    localparam int TO   = 300;
    localparam int AW   = 8;
    localparam int HALF = 10;

    logic clk;
    logic rst;
    ps2_mouse_quad_if bus ();

    ps2_mouse_quad #(.STEP_DIV(SD), .TIMEOUT(TO), .ACC_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int x_cnt = 0, y_cnt = 0;
    int bad_x = 0, bad_y = 0;
    int chg_cnt = 0;
    int last_x = -1000, last_y = -1000;
    logic [6:0] prev_q = 7'h70;

    function automatic int ph(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int dir(input logic [1:0] a, input logic [1:0] b);
        return (ph(b) - ph(a)) & 3;
    endfunction

    function automatic logic spacing_bad(input int now, input int last);
        return ((now - last) < 3 * SD) && ((now - last) != SD);
    endfunction

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        prev_q <= bus.quad;
        if (!rst) begin
            last_x  <= -1000;
            last_y  <= -1000;
            chg_cnt <= 0;
        end else begin
            if (bus.quad != prev_q) chg_cnt <= chg_cnt + 1;
            if (bus.quad[3:2] != prev_q[3:2]) begin
                last_x <= cyc;
                if (dir(prev_q[3:2], bus.quad[3:2]) == 1)      x_cnt <= x_cnt + 1;
                else if (dir(prev_q[3:2], bus.quad[3:2]) == 3) x_cnt <= x_cnt - 1;
                if (dir(prev_q[3:2], bus.quad[3:2]) == 2 || spacing_bad(cyc, last_x))
                    bad_x <= bad_x + 1;
            end
            if (bus.quad[1:0] != prev_q[1:0]) begin
                last_y <= cyc;
                if (dir(prev_q[1:0], bus.quad[1:0]) == 1)      y_cnt <= y_cnt + 1;
                else if (dir(prev_q[1:0], bus.quad[1:0]) == 3) y_cnt <= y_cnt - 1;
                if (dir(prev_q[1:0], bus.quad[1:0]) == 2 || spacing_bad(cyc, last_y))
                    bad_y <= bad_y + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.msdat = b;
        wait_clk(HALF);
        bus.msclk = 1'b0;
        wait_clk(HALF);
        bus.msclk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(1'b1);
        bus.msdat = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic bad1);
        send_byte(b0, 1'b0);
        send_byte(b1, bad1);
        send_byte(b2, 1'b0);
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0);
        for (int i = 1; i < nbits; i++) send_bit(i[0]);
        bus.msdat = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         ex, ey;
        logic [2:0] keys;   // expected quad[6:4]
    } vec_t;

    vec_t vecs[10];
    int x0, y0, n;
    int exp_par;

    initial begin
        vecs[0] = '{8'h08, 8'h05, 8'h00,    5,    0, 3'b111};
        vecs[1] = '{8'h38, 8'hFB, 8'hFE,   -5,   -2, 3'b111};
        vecs[2] = '{8'h09, 8'h00, 8'h00,    0,    0, 3'b011};
        vecs[3] = '{8'h08, 8'h00, 8'h00,    0,    0, 3'b111};
        vecs[4] = '{8'h0E, 8'h01, 8'h03,    1,    3, 3'b100};
        vecs[5] = '{8'h48, 8'h05, 8'h03,    0,    3, 3'b111};
        vecs[6] = '{8'h88, 8'h05, 8'h03,    5,    0, 3'b111};
        vecs[7] = '{8'h08, 8'hFF, 8'h00,  127,    0, 3'b111};
        vecs[8] = '{8'h18, 8'h00, 8'h00, -127,    0, 3'b111};
        vecs[9] = '{8'h28, 8'h00, 8'h80,    0, -127, 3'b111};

        rst = 1'b0;
        bus.msclk = 1'b1;
        bus.msdat = 1'b1;
        wait_clk(5);
        check("reset_quad", int'(bus.quad), 'h70);
        rst = 1'b1;

        // Idle lines: nothing may move
        wait_clk(20000);
        check("idle_quad", int'(bus.quad), 'h70);
        check("idle_changes", chg_cnt, 0);

        for (int i = 0; i < 10; i++) begin
            x0 = x_cnt;
            y0 = y_cnt;
            send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, 1'b0);
            n = (vecs[i].ex < 0) ? -vecs[i].ex : vecs[i].ex;
            if (vecs[i].ey > n)  n = vecs[i].ey;
            if (-vecs[i].ey > n) n = -vecs[i].ey;
            wait_clk((n + 3) * SD);
            check($sformatf("vec%0d_x", i), x_cnt - x0, vecs[i].ex);
            check($sformatf("vec%0d_y", i), y_cnt - y0, vecs[i].ey);
            check($sformatf("vec%0d_keys", i), int'(bus.quad[6:4]), int'(vecs[i].keys));
        end

        // Header without bit3 is discarded, next packet decodes
        x0 = x_cnt;
        send_byte(8'h00, 1'b0);
        send_pkt(8'h08, 8'h03, 8'h00, 1'b0);
        wait_clk(6 * SD);
        check("resync_x", x_cnt - x0, 3);

        // Partial frame abandoned after silence
        x0 = x_cnt;
        send_partial(5);
        wait_clk(TO + 50);
        send_pkt(8'h08, 8'h02, 8'h00, 1'b0);
        wait_clk(5 * SD);
        check("timeout_x", x_cnt - x0, 2);

        // Bad parity on byte1
`ifdef MQ_PARITY_EN
        exp_par = 0;
`else
        exp_par = 5;
`endif
        x0 = x_cnt;
        send_pkt(8'h08, 8'h05, 8'h00, 1'b1);
        wait_clk(8 * SD);
        check("parity_x", x_cnt - x0, exp_par);
        x0 = x_cnt;
        send_pkt(8'h08, 8'h01, 8'h00, 1'b0);
        wait_clk(4 * SD);
        check("after_parity_x", x_cnt - x0, 1);

        // Reset mid-emission loses pending steps
        send_pkt(8'h08, 8'h7F, 8'h00, 1'b0);
        wait_clk(5 * SD);
        rst = 1'b0;
        wait_clk(3);
        check("rst_emit_quad", int'(bus.quad), 'h70);
        rst = 1'b1;
        x0 = x_cnt;
        wait_clk(20 * SD);
        check("rst_emit_idle_x", x_cnt - x0, 0);
        check("rst_emit_idle_quad", int'(bus.quad), 'h70);

        // Reset mid-frame, then a fresh packet decodes
        send_partial(6);
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        x0 = x_cnt;
        send_pkt(8'h08, 8'h02, 8'h00, 1'b0);
        wait_clk(5 * SD);
        check("rst_frame_x", x_cnt - x0, 2);

        check("x_step_legality", bad_x, 0);
        check("y_step_legality", bad_y, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
